// File: rtl/clock_display_driver.sv
// clock_display_driver: scans a snapshot of sec/min onto a 4-digit
// common-anode 7-segment display in MM:SS format, one digit per SCAN_DIV clocks.
// Ports: clk, rst_n (async, active-low); sec/min binary time inputs (0..59);
//        an digit enables, seg {g,f,e,d,c,b,a}, dp (all active-low);
//        frame_start pulses for one cycle after each snapshot capture.
// Optional: define COLON_BLINK_EN to drive dp low on min-ones for even seconds.
module clock_display_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    dig_q, dig_d;
    logic [5:0]    snap_sec_q, snap_sec_d;
    logic [5:0]    snap_min_q, snap_min_d;
    logic          first_q;
    logic          fs_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          tick, cap;
    logic [5:0]    src_sec, src_min, fld;
    logic [3:0]    val;

    function automatic logic [3:0] tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] ones(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        tick       = (pre_q == LAST);
        cap        = first_q | (tick & (dig_q == 2'd3));
        pre_d      = tick ? '0 : pre_q + 1'b1;
        dig_d      = tick ? dig_q + 2'd1 : dig_q;
        snap_sec_d = cap ? sec : snap_sec_q;
        snap_min_d = cap ? min : snap_min_q;
        // On the very first edge the snapshot is being loaded in the same
        // edge as the first digit is driven, so decode straight from inputs.
        src_sec    = first_q ? sec : snap_sec_q;
        src_min    = first_q ? min : snap_min_q;
        fld        = dig_q[1] ? src_min : src_sec;
        val        = dig_q[0] ? tens(fld) : ones(fld);
        seg_d      = (fld > 6'd59) ? 7'b0111111 : seg_code(val);
        an_d       = ~(4'b0001 << dig_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= '0;
            dig_q      <= '0;
            snap_sec_q <= '0;
            snap_min_q <= '0;
            first_q    <= 1'b1;
            fs_q       <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
        end else begin
            pre_q      <= pre_d;
            dig_q      <= dig_d;
            snap_sec_q <= snap_sec_d;
            snap_min_q <= snap_min_d;
            first_q    <= 1'b0;
            fs_q       <= cap;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

`ifdef COLON_BLINK_EN
    logic dp_q, dp_d;

    always_comb begin
        dp_d = ~((dig_q == 2'd2) & ~src_sec[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q <= 1'b1;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign dp = dp_q;
`else
    assign dp = 1'b1;
`endif

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// tb_clock_display_driver: directed frame-by-frame checks of the
// 7-segment scan driver with SCAN_DIV=4 (16-cycle frames).
module tb_clock_display_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] sec = 6'd7;
    logic [5:0] min = 6'd42;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clock_display_driver #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sec        (sec),
        .min        (min),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // 10 encodes the out-of-range dash
    function automatic logic [6:0] sc(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic run_frame(input bit first, input int d0, input int d1,
                             input int d2, input int d3, input bit even,
                             input logic [5:0] ns, input logic [5:0] nm);
        int dg[4];
        int d;
        logic [3:0] ea;
        logic ed;
        dg = '{d0, d1, d2, d3};
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            d  = i / 4;
            ea = ~(4'b0001 << d);
            ed = 1'b1;
`ifdef COLON_BLINK_EN
            ed = !(d == 2 && even);
`endif
            check($sformatf("an[%0d]", i), an, ea);
            check($sformatf("seg[%0d]", i), seg, sc(dg[d]));
            check($sformatf("fs[%0d]", i), frame_start,
                  (first && i == 0) || i == 15);
            check($sformatf("dp[%0d]", i), dp, ed);
            if (i == 5) begin
                sec = ns;
                min = nm;
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, 7'b1111111);
        check("rst_dp", dp, 1'b1);
        check("rst_fs", frame_start, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_frame(1, 7, 0, 2, 4, 0, 6'd8, 6'd42);
        run_frame(0, 8, 0, 2, 4, 1, 6'd63, 6'd5);
        run_frame(0, 10, 10, 5, 0, 0, 6'd59, 6'd59);
        run_frame(0, 9, 5, 9, 5, 0, 6'd0, 6'd0);
        run_frame(0, 0, 0, 0, 0, 1, 6'd10, 6'd0);
        run_frame(0, 0, 1, 0, 0, 1, 6'd11, 6'd0);
        run_frame(0, 1, 1, 0, 0, 0, 6'd11, 6'd0);

        repeat (9) @(posedge clk);
        #2;
        check("mid_an", an, 4'b1011);
        rst_n = 1'b0;
        #1;
        check("arst_an", an, 4'b1111);
        check("arst_seg", seg, 7'b1111111);
        check("arst_dp", dp, 1'b1);
        check("arst_fs", frame_start, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1, 1, 1, 0, 0, 0, 6'd11, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
